// File: rtl/tdiv_pkg.sv
// Purpose : shared definitions for the sequential restoring divider (state encoding, default width).
// Latency : n/a (declarations only).
// Backpressure : n/a.
package tdiv_pkg;

    localparam int TDIV_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tdiv_step.sv
// Purpose : one combinational restoring-division iteration (shift in a dividend bit, trial subtract).
// Latency : 0 cycles, purely combinational.
// Backpressure : none; evaluated every cycle, the caller decides when to register the result.
//
// Ports:
//   r     - current partial remainder (always < d, so WIDTH bits suffice)
//   q_msb - dividend/quotient shift-register MSB shifted into the remainder
//   d     - divisor
//   r_nxt - next partial remainder
//   q_bit - quotient bit produced by this iteration
module tdiv_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_nxt,
    output logic             q_bit
);

    // Trial value is WIDTH+1 bits wide so the compare never overflows.
    logic [WIDTH:0] t;

    assign t     = {r, q_msb};
    assign q_bit = (t >= {1'b0, d});
    // When the subtract is taken the true result is < d, so modulo-2^WIDTH
    // arithmetic on the low bits gives the exact value.
    assign r_nxt = q_bit ? (t[WIDTH-1:0] - d) : t[WIDTH-1:0];

endmodule

// File: rtl/tdiv_seq.sv
// Purpose : sequential unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Latency : oDone rises WIDTH+1 edges after the accepting edge (1 edge for a zero divisor).
// Backpressure : none queued; iStart is ignored unless the FSM is in IDLE.
//
// Ports:
//   Clock, Reset (synchronous, active-low)
//   iStart, iDividend, iDivisor            - request, operands captured on acceptance
//   oBusy                                  - high in RUN and DONE
//   oDone                                  - one-cycle pulse, results valid from then on
//   oQuotient, oRemainder, oDivByZero      - held until the next accepted start
module tdiv_seq
    import tdiv_pkg::*;
#(
    parameter int WIDTH = TDIV_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iDividend,
    input  logic [WIDTH-1:0] iDivisor,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oQuotient,
    output logic [WIDTH-1:0] oRemainder,
    output logic             oDivByZero
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q;      // dividend shifts out the top, quotient shifts in the bottom
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_nxt;
    logic             q_bit;

    tdiv_step #(.WIDTH(WIDTH)) u_step (
        .r     (r),
        .q_msb (q[WIDTH-1]),
        .d     (d),
        .r_nxt (r_nxt),
        .q_bit (q_bit)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            q          <= '0;
            d          <= '0;
            r          <= '0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oQuotient  <= '0;
            oRemainder <= '0;
            oDivByZero <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        q          <= iDividend;
                        d          <= iDivisor;
                        r          <= '0;
                        cnt        <= CW'(WIDTH - 1);
                        oBusy      <= 1'b1;
                        oQuotient  <= '0;
                        oRemainder <= '0;
                        oDivByZero <= 1'b0;
                        // A zero divisor skips the iterations; q still holds
                        // the dividend, which becomes the reported remainder.
                        state      <= (iDivisor == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    r <= r_nxt;
                    q <= {q[WIDTH-2:0], q_bit};
                    if (cnt == '0) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    oDone <= 1'b1;
                    oBusy <= 1'b0;
                    state <= ST_IDLE;
                    if (d == '0) begin
                        oQuotient  <= '1;
                        oRemainder <= q;
                        oDivByZero <= 1'b1;
                    end else begin
                        oQuotient  <= q;
                        oRemainder <= r;
                        oDivByZero <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdiv_seq.sv
module tb_tdiv_seq;

    localparam int W = 16;

    logic         Clock;
    logic         Reset;
    logic         iStart;
    logic [W-1:0] iDividend;
    logic [W-1:0] iDivisor;
    logic         oBusy;
    logic         oDone;
    logic [W-1:0] oQuotient;
    logic [W-1:0] oRemainder;
    logic         oDivByZero;

    int n_checks = 0;
    int n_fails  = 0;

    tdiv_seq #(.WIDTH(W)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .iStart     (iStart),
        .iDividend  (iDividend),
        .iDivisor   (iDivisor),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oQuotient  (oQuotient),
        .oRemainder (oRemainder),
        .oDivByZero (oDivByZero)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Called just after an edge S: presents a one-cycle start, then waits
    // (bounded) for oDone. lat counts edges from S to the oDone rising edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        iStart    = 1'b1;
        iDividend = a;
        iDivisor  = b;
        tick();
        iStart    = 1'b0;
        iDividend = $urandom_range(0, 65535);
        iDivisor  = $urandom_range(0, 65535);
        lat = 1;
        while (!oDone && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int seen;
        logic [W-1:0] a, b;
        logic [31:0] pq, pr;

        Reset     = 1'b0;
        iStart    = 1'b0;
        iDividend = '0;
        iDivisor  = '0;
        repeat (3) tick();
        chk("rst_busy", {31'd0, oBusy}, 0);
        chk("rst_done", {31'd0, oDone}, 0);
        chk("rst_quot", {16'd0, oQuotient}, 0);
        chk("rst_rem",  {16'd0, oRemainder}, 0);
        chk("rst_dz",   {31'd0, oDivByZero}, 0);
        Reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (oDone || oBusy) seen++;
        end
        chk("idle_40_quiet", seen, 0);

        // 1000 / 7 = 142 rem 6
        run_op(16'd1000, 16'd7, lat);
        chk("d1000_lat",  lat, 18);
        chk("d1000_quot", {16'd0, oQuotient}, 142);
        chk("d1000_rem",  {16'd0, oRemainder}, 6);
        chk("d1000_dz",   {31'd0, oDivByZero}, 0);
        tick();
        chk("d1000_done_pulse", {31'd0, oDone}, 0);
        repeat (5) tick();
        chk("d1000_hold_quot", {16'd0, oQuotient}, 142);
        chk("d1000_hold_rem",  {16'd0, oRemainder}, 6);

        run_op(16'hFFFF, 16'd1, lat);
        chk("ffff_quot", {16'd0, oQuotient}, 32'hFFFF);
        chk("ffff_rem",  {16'd0, oRemainder}, 0);
        tick();

        run_op(16'd5, 16'd9, lat);
        chk("d5_9_quot", {16'd0, oQuotient}, 0);
        chk("d5_9_rem",  {16'd0, oRemainder}, 5);
        tick();

        run_op(16'd0, 16'd5, lat);
        chk("d0_quot", {16'd0, oQuotient}, 0);
        chk("d0_rem",  {16'd0, oRemainder}, 0);
        tick();

        // Divide by zero
        run_op(16'd1234, 16'd0, lat);
        chk("dz_lat",  lat, 2);
        chk("dz_quot", {16'd0, oQuotient}, 32'hFFFF);
        chk("dz_rem",  {16'd0, oRemainder}, 1234);
        chk("dz_flag", {31'd0, oDivByZero}, 1);
        tick();

        // Start while busy: the second request must be dropped.
        iStart = 1'b1; iDividend = 16'd100; iDivisor = 16'd3;
        tick();
        iStart = 1'b0;
        chk("busy_after_start", {31'd0, oBusy}, 1);
        repeat (3) tick();
        iStart = 1'b1; iDividend = 16'd50; iDivisor = 16'd5;
        tick();
        iStart = 1'b0;
        lat = 0;
        while (!oDone && lat < 100) begin
            tick();
            lat++;
        end
        chk("busy_quot", {16'd0, oQuotient}, 33);
        chk("busy_rem",  {16'd0, oRemainder}, 1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (oDone) seen++;
        end
        chk("busy_single_done", seen, 0);

        // Reset in the middle of RUN
        iStart = 1'b1; iDividend = 16'd60000; iDivisor = 16'd7;
        tick();
        iStart = 1'b0;
        repeat (7) tick();
        Reset = 1'b0;
        tick();
        chk("mid_rst_busy", {31'd0, oBusy}, 0);
        chk("mid_rst_quot", {16'd0, oQuotient}, 0);
        chk("mid_rst_rem",  {16'd0, oRemainder}, 0);
        chk("mid_rst_done", {31'd0, oDone}, 0);
        Reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (oDone || oBusy) seen++;
        end
        chk("mid_rst_no_result", seen, 0);
        run_op(16'd9, 16'd2, lat);
        chk("after_rst_lat",  lat, 18);
        chk("after_rst_quot", {16'd0, oQuotient}, 4);
        chk("after_rst_rem",  {16'd0, oRemainder}, 1);

        // Back-to-back: start immediately in the idle cycle carrying oDone.
        run_op(16'd7, 16'd7, lat);
        chk("b2b_lat",  lat, 18);
        chk("b2b_quot", {16'd0, oQuotient}, 1);
        chk("b2b_rem",  {16'd0, oRemainder}, 0);
        run_op(16'd65535, 16'd256, lat);
        chk("b2b2_lat",  lat, 18);
        chk("b2b2_quot", {16'd0, oQuotient}, 255);
        chk("b2b2_rem",  {16'd0, oRemainder}, 255);
        tick();

        // Corners then random operands against an independent reference.
        for (int i = 0; i < 320; i++) begin
            case (i)
                0: begin a = 16'h0000; b = 16'hFFFF; end
                1: begin a = 16'hFFFF; b = 16'hFFFF; end
                2: begin a = 16'hFFFF; b = 16'hFFFE; end
                3: begin a = 16'hFFFE; b = 16'hFFFF; end
                4: begin a = 16'h8000; b = 16'h0002; end
                5: begin a = 16'h0000; b = 16'h0000; end
                default: begin
                    a = 16'($urandom_range(0, 65535));
                    b = (i % 10 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom_range(0, 65535));
                end
            endcase
            run_op(a, b, lat);
            if (b == 0) begin
                pq = 32'hFFFF;
                pr = {16'd0, a};
            end else begin
                pq = {16'd0, a / b};
                pr = {16'd0, a % b};
            end
            chk("rnd_lat",  lat, (b == 0) ? 2 : 18);
            chk("rnd_quot", {16'd0, oQuotient}, pq);
            chk("rnd_rem",  {16'd0, oRemainder}, pr);
            chk("rnd_dz",   {31'd0, oDivByZero}, {31'd0, (b == 0)});
            if (b != 0) begin
                chk("rnd_identity", {16'd0, oQuotient} * {16'd0, b} + {16'd0, oRemainder}, {16'd0, a});
                chk("rnd_rem_lt_div", {31'd0, (oRemainder < b)}, 1);
            end
            if (i % 4 == 1) begin
                repeat (3) tick();
                chk("rnd_hold_quot", {16'd0, oQuotient}, pq);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
